// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// fault counter width and the shared counter width calculation.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } reset_seq_state_t;

    localparam int FAULT_CNT_W = 8;

    // Width able to hold the largest of the three programmable counts.
    function automatic int cnt_width(input int hold_cyc, input int lock_filt, input int stage_dly);
        int max_v;
        max_v = hold_cyc;
        if (lock_filt > max_v) begin
            max_v = lock_filt;
        end else begin
            max_v = max_v;
        end
        if (stage_dly > max_v) begin
            max_v = stage_dly;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/reset_seq_lock_debounce.sv
// Consecutive-high filter on the clock-lock indication. lock_ok_o flags the
// edge on which lock_i completes its LOCK_FILT-th consecutive high sample.
module lock_debounce #(
    parameter int LOCK_FILT = 8,
    parameter int CW        = 6
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic lock_i,
    output logic lock_ok_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive high samples, saturating at LOCK_FILT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !lock_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(LOCK_FILT)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Filter counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Feeds only the sequencer next-state logic, never a module output.
    assign lock_ok_o = lock_i && (cnt_q >= CW'(LOCK_FILT - 1));

endmodule

// File: rtl/reset_seq.sv
// Ordered reset release sequencer gated by clock lock. Optional lock-loss
// fault counter is enabled by defining RESET_SEQ_FAULT_CNT_EN.
module reset_seq #(
    parameter int N_STAGES  = 4,
    parameter int HOLD_CYC  = 32,
    parameter int LOCK_FILT = 8,
    parameter int STAGE_DLY = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  lock_in,
    input  logic                                  sw_rst_req,
    output logic [N_STAGES-1:0]                   resetn_out,
    output logic                                  done,
    output logic                                  busy,
    output logic [reset_seq_pkg::FAULT_CNT_W-1:0] fault_cnt
);

    import reset_seq_pkg::*;

    localparam int CW = cnt_width(HOLD_CYC, LOCK_FILT, STAGE_DLY);
    localparam int IW = $clog2(N_STAGES + 1);

    reset_seq_state_t  state_q;
    reset_seq_state_t  state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [N_STAGES-1:0] resetn_q;
    logic [N_STAGES-1:0] resetn_d;
    logic              done_q;
    logic              done_d;
    logic              busy_q;
    logic              busy_d;
    logic              lock_ok_s;
    logic              filt_clr_s;

    assign filt_clr_s = (state_q != WAIT_LOCK);

    lock_debounce #(
        .LOCK_FILT (LOCK_FILT),
        .CW        (CW)
    ) u_lock_debounce (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     (filt_clr_s),
        .lock_i    (lock_in),
        .lock_ok_o (lock_ok_s)
    );

    // Sequencer next-state: a fault always wins over a release due on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        resetn_d = resetn_q;
        case (state_q)
            HOLD: begin
                resetn_d = '0;
                idx_d    = '0;
                if (sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (sw_rst_req) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    idx_d    = '0;
                    resetn_d = '0;
                end else if (lock_ok_s) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            RELEASE: begin
                if (!lock_in || sw_rst_req) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    idx_d    = '0;
                    resetn_d = '0;
                end else if (cnt_q == CW'(STAGE_DLY - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    for (int k = 0; k < N_STAGES; k++) begin
                        if (IW'(k) == idx_q) begin
                            resetn_d[k] = 1'b1;
                        end else begin
                            resetn_d[k] = resetn_q[k];
                        end
                    end
                    if (idx_q == IW'(N_STAGES - 1)) begin
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_in || sw_rst_req) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    idx_d    = '0;
                    resetn_d = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = HOLD;
                cnt_d    = '0;
                idx_d    = '0;
                resetn_d = '0;
            end
        endcase
        done_d = (state_d == RUN);
        busy_d = (state_d != RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            resetn_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            resetn_q <= resetn_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign resetn_out = resetn_q;
    assign done       = done_q;
    assign busy       = busy_q;

`ifdef RESET_SEQ_FAULT_CNT_EN
    logic                   lock_fault_s;
    logic [FAULT_CNT_W-1:0] fault_cnt_q;

    // Software requests are deliberately not counted, only lock loss.
    assign lock_fault_s = !lock_in && ((state_q == RELEASE) || (state_q == RUN));

    // Saturating lock-loss counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_cnt_q <= '0;
        end else if (lock_fault_s && (fault_cnt_q != {FAULT_CNT_W{1'b1}})) begin
            fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
        end else begin
            fault_cnt_q <= fault_cnt_q;
        end
    end

    assign fault_cnt = fault_cnt_q;
`else
    assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with hand-derived release edges.
module tb_reset_seq;

`ifdef RESET_SEQ_FAULT_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       lock_in;
    logic       sw_rst_req;
    logic [3:0] resetn_out;
    logic       done;
    logic       busy;
    logic [7:0] fault_cnt;

    int checks;
    int errors;
    int edge_n;

    reset_seq #(
        .N_STAGES  (4),
        .HOLD_CYC  (32),
        .LOCK_FILT (8),
        .STAGE_DLY (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock_in    (lock_in),
        .sw_rst_req (sw_rst_req),
        .resetn_out (resetn_out),
        .done       (done),
        .busy       (busy),
        .fault_cnt  (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic [31:0] fexp(input int n);
        if (!FC_EN) return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sw_rst_req = 1'b0;
        lock_in    = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        reset = 1'b1; lock_in = 1'b0; sw_rst_req = 1'b0;

        // 1: clean power-up
        do_reset();
        check("rst_resetn", 32'(resetn_out), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_busy",   32'(busy), 32'h1);
        check("rst_fault",  32'(fault_cnt), 32'h0);
        run_to(55);  check("s1_e55",  32'(resetn_out), 32'h0);
        run_to(56);  check("s1_e56",  32'(resetn_out), 32'h1);
        run_to(71);  check("s1_e71",  32'(resetn_out), 32'h1);
        run_to(72);  check("s1_e72",  32'(resetn_out), 32'h3);
        run_to(88);  check("s1_e88",  32'(resetn_out), 32'h7);
        run_to(103); check("s1_e103_done", 32'(done), 32'h0);
                     check("s1_e103_busy", 32'(busy), 32'h1);
        run_to(104); check("s1_e104", 32'(resetn_out), 32'hF);
                     check("s1_e104_done", 32'(done), 32'h1);
                     check("s1_e104_busy", 32'(busy), 32'h0);

        // 2: lock glitch in WAIT_LOCK, then 3: lock loss in RUN
        do_reset();
        run_to(35);
        lock_in = 1'b0; tick(); lock_in = 1'b1;
        check("s2_fault", 32'(fault_cnt), 32'h0);
        run_to(59);  check("s2_e59", 32'(resetn_out), 32'h0);
        run_to(60);  check("s2_e60", 32'(resetn_out), 32'h1);
        run_to(108); check("s2_e108", 32'(resetn_out), 32'hF);
        run_to(199);
        lock_in = 1'b0; tick(); lock_in = 1'b1;
        check("s3_resetn", 32'(resetn_out), 32'h0);
        check("s3_done",   32'(done), 32'h0);
        check("s3_busy",   32'(busy), 32'h1);
        check("s3_fault",  32'(fault_cnt), fexp(1));
        run_to(255); check("s3_e255", 32'(resetn_out), 32'h0);
        run_to(256); check("s3_e256", 32'(resetn_out), 32'h1);

        // 4: software reset mid-RELEASE
        do_reset();
        run_to(79);  check("s4_e79", 32'(resetn_out), 32'h3);
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        check("s4_resetn", 32'(resetn_out), 32'h0);
        check("s4_done",   32'(done), 32'h0);
        check("s4_fault",  32'(fault_cnt), 32'h0);
        run_to(135); check("s4_e135", 32'(resetn_out), 32'h0);
        run_to(136); check("s4_e136", 32'(resetn_out), 32'h1);

        // 4b: software request during HOLD restarts the hold count
        do_reset();
        run_to(9);
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        run_to(65);  check("s4b_e65", 32'(resetn_out), 32'h0);
        run_to(66);  check("s4b_e66", 32'(resetn_out), 32'h1);

        // 5: software reset on the final release edge
        do_reset();
        run_to(103); check("s5_e103", 32'(resetn_out), 32'h7);
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        check("s5_resetn", 32'(resetn_out), 32'h0);
        check("s5_done",   32'(done), 32'h0);
        run_to(130); check("s5_e130", 32'(resetn_out), 32'h0);
        check("s5_e130_done", 32'(done), 32'h0);

        // 6: reset mid-RUN after one counted fault, then saturation
        do_reset();
        run_to(60);
        lock_in = 1'b0; tick(); lock_in = 1'b1;
        check("s6_pre_fault", 32'(fault_cnt), fexp(1));
        run_to(61 + 104);
        check("s6_run_done", 32'(done), 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        edge_n = 0;
        check("s6_rst_resetn", 32'(resetn_out), 32'h0);
        check("s6_rst_done",   32'(done), 32'h0);
        check("s6_rst_busy",   32'(busy), 32'h1);
        check("s6_rst_fault",  32'(fault_cnt), 32'h0);
        for (int n = 1; n <= 300; n++) begin
            for (int c = 0; c < 40; c++) tick();
            lock_in = 1'b0; tick(); lock_in = 1'b1;
            if (n == 3)   check("s6_cnt3",   32'(fault_cnt), fexp(3));
            if (n == 255) check("s6_cnt255", 32'(fault_cnt), fexp(255));
        end
        check("s6_cnt300", 32'(fault_cnt), fexp(300));
        check("s6_cnt300_resetn", 32'(resetn_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
